// File: rtl/bsg_mesh_router_pkg.sv
// Shared types and helpers for the mesh router output scheduler.
package bsg_mesh_router_pkg;

    // Output-port scheduling state: free arbitration vs. held by one input for a packet.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    // Round-robin successor of idx among n inputs.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bsg_mesh_router_credit_counter.sv
// Up/down downstream credit counter, resets full and saturates at credits_p.
module bsg_mesh_router_credit_counter #(
    parameter int credits_p    = 2,
    parameter int cnt_width_lp = $clog2(credits_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    up,
    input  logic                    down,
    output logic [cnt_width_lp-1:0] count
);

    localparam logic [cnt_width_lp-1:0] max_lp = cnt_width_lp'(credits_p);

    logic [cnt_width_lp-1:0] count_q, count_d;

    // Next count: simultaneous up/down cancel; both ends clamp.
    always_comb begin
        count_d = count_q;
        if (up && !down) begin
            count_d = (count_q == max_lp) ? count_q : count_q + cnt_width_lp'(1);
        end else if (down && !up) begin
            count_d = (count_q == '0) ? count_q : count_q - cnt_width_lp'(1);
        end
    end

    // Count register, full on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= max_lp;
        end else begin
            count_q <= count_d;
        end
    end

    // A returned credit with no room means the downstream returned more than it was sent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(up && !down && count_q == max_lp))
            else $error("credit returned while credit counter already full");
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bsg_mesh_router_out_sched.sv
// Mesh router output-port scheduler: round-robin over input FIFOs, packet locking on
// header length, credit-based flow control toward the downstream FIFO.
// Optional stall statistics enabled by defining BSG_MESH_ROUTER_OUT_SCHED_STATS_EN.
module bsg_mesh_router_out_sched
    import bsg_mesh_router_pkg::*;
#(
    parameter int width_p     = -1,
    parameter int num_in_p    = 5,
    parameter int credits_p   = 2,
    parameter int len_width_p = 4,
    localparam int cred_width_lp = $clog2(credits_p + 1),
    localparam int ptr_width_lp  = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_in_p-1:0]                v_i,
    input  logic [num_in_p-1:0][width_p-1:0]   data_i,
    output logic [num_in_p-1:0]                yumi_o,
    output logic                               v_o,
    output logic [width_p-1:0]                 data_o,
    input  logic                               credit_i,
    output logic [cred_width_lp-1:0]           credits_o,
    output logic [31:0]                        stall_cnt_o
);

    sched_state_e               state_q, state_d;
    logic [ptr_width_lp-1:0]    ptr_q, ptr_d;
    logic [ptr_width_lp-1:0]    lock_q, lock_d;
    logic [len_width_p-1:0]     remaining_q, remaining_d;

    logic [ptr_width_lp-1:0]    grant;
    logic                       grant_v;
    logic [ptr_width_lp:0]      scan_sum;
    logic [len_width_p-1:0]     header_len;

    // Grant selection: locked input only, else first valid at or after ptr (wrapping).
    always_comb begin
        grant    = ptr_q;
        grant_v  = 1'b0;
        scan_sum = '0;
        if (state_q == LOCKED) begin
            grant   = lock_q;
            grant_v = v_i[lock_q];
        end else begin
            for (int k = 0; k < num_in_p; k++) begin
                scan_sum = {1'b0, ptr_q} + (ptr_width_lp + 1)'(k);
                if (scan_sum >= (ptr_width_lp + 1)'(num_in_p)) begin
                    scan_sum = scan_sum - (ptr_width_lp + 1)'(num_in_p);
                end
                if (!grant_v && v_i[scan_sum[ptr_width_lp-1:0]]) begin
                    grant_v = 1'b1;
                    grant   = scan_sum[ptr_width_lp-1:0];
                end
            end
        end
    end

    // Send only with a credit in hand; a credit arriving this cycle is usable next cycle.
    assign v_o        = grant_v && (credits_o != '0) && !reset_i;
    assign data_o     = data_i[grant];
    assign header_len = data_o[len_width_p-1:0];

    // Dequeue strobe to the granted input only.
    always_comb begin
        yumi_o        = '0;
        yumi_o[grant] = v_o;
    end

    // Packet-lock FSM and round-robin pointer advance on each send.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        remaining_d = remaining_q;
        if (v_o) begin
            if (state_q == IDLE) begin
                if (header_len == '0) begin
                    ptr_d = ptr_width_lp'(wrap_inc(32'(grant), num_in_p));
                end else begin
                    state_d     = LOCKED;
                    lock_d      = grant;
                    remaining_d = header_len;
                end
            end else begin
                remaining_d = remaining_q - len_width_p'(1);
                if (remaining_q == len_width_p'(1)) begin
                    state_d = IDLE;
                    ptr_d   = ptr_width_lp'(wrap_inc(32'(lock_q), num_in_p));
                end
            end
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lock_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            remaining_q <= remaining_d;
        end
    end

    bsg_mesh_router_credit_counter #(
        .credits_p (credits_p)
    ) u_credit_counter (
        .clk   (clk_i),
        .reset (reset_i),
        .up    (credit_i),
        .down  (v_o),
        .count (credits_o)
    );

`ifdef BSG_MESH_ROUTER_OUT_SCHED_STATS_EN
    logic [31:0] stall_cnt_q;

    // Count cycles where a flit is ready but no downstream slot is available.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (grant_v && (credits_o == '0) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_mesh_router_out_sched.sv
// Self-checking bench for bsg_mesh_router_out_sched: directed table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_bsg_mesh_router_out_sched;

    localparam int W  = 8;
    localparam int N  = 5;
    localparam int C  = 2;
    localparam int LW = 4;

`ifdef BSG_MESH_ROUTER_OUT_SCHED_STATS_EN
    localparam bit stats_en = 1'b1;
`else
    localparam bit stats_en = 1'b0;
`endif

    logic                clk;
    logic                reset_i;
    logic [N-1:0]        v_i;
    logic [N-1:0][W-1:0] data_i;
    logic [N-1:0]        yumi_o;
    logic                v_o;
    logic [W-1:0]        data_o;
    logic                credit_i;
    logic [1:0]          credits_o;
    logic [31:0]         stall_cnt_o;

    bsg_mesh_router_out_sched #(
        .width_p     (W),
        .num_in_p    (N),
        .credits_p   (C),
        .len_width_p (LW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .yumi_o      (yumi_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .credit_i    (credit_i),
        .credits_o   (credits_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: packet-level view of the output port.
    bit          m_locked = 1'b0;
    int          m_ptr    = 0;
    int          m_lock   = 0;
    int          m_rem    = 0;
    int          m_cred   = C;
    longint      m_stall  = 0;
    int          e_g;
    bit          e_v;
    logic [N-1:0] e_yumi;
    logic [W-1:0] e_data;

    task automatic model_eval();
        e_g = -1;
        if (m_locked) begin
            if (v_i[m_lock]) e_g = m_lock;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (e_g < 0 && v_i[idx]) e_g = idx;
            end
        end
        e_v    = (e_g >= 0) && (m_cred > 0) && !reset_i;
        e_yumi = '0;
        if (e_v) e_yumi[e_g] = 1'b1;
        e_data = (e_g >= 0) ? data_i[e_g] : '0;
    endtask

    task automatic model_step();
        int len;
        if (reset_i) begin
            m_locked = 1'b0; m_ptr = 0; m_lock = 0; m_rem = 0; m_cred = C; m_stall = 0;
        end else begin
            if (stats_en && e_g >= 0 && m_cred == 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e_v) begin
                if (m_locked) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_locked = 1'b0;
                        m_ptr    = (m_lock + 1) % N;
                    end
                end else begin
                    len = int'(e_data[LW-1:0]);
                    if (len == 0) begin
                        m_ptr = (e_g + 1) % N;
                    end else begin
                        m_locked = 1'b1; m_lock = e_g; m_rem = len;
                    end
                end
            end
            m_cred = m_cred + int'(credit_i) - int'(e_v);
            if (m_cred > C) m_cred = C;
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0][W-1:0] d,
                         input logic c);
        @(negedge clk);
        reset_i  = r;
        v_i      = v;
        data_i   = d;
        credit_i = c;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
    endtask

    task automatic model_check(input string tag);
        chk({tag, "_v_o"}, v_o, e_v);
        chk({tag, "_yumi_o"}, yumi_o, e_yumi);
        if (e_v) chk({tag, "_data_o"}, data_o, e_data);
        chk({tag, "_credits_o"}, credits_o, m_cred);
        chk({tag, "_stall_cnt_o"}, stall_cnt_o, m_stall);
    endtask

    typedef struct {
        logic                rst;
        logic [N-1:0]        v;
        logic [N-1:0][W-1:0] d;
        logic                c;
        logic                exp_v;
        logic [N-1:0]        exp_yumi;
        logic [W-1:0]        exp_data;
        logic [1:0]          exp_cred;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [N-1:0] v, input logic [N-1:0][W-1:0] d,
                       input logic c, input logic ev, input logic [N-1:0] ey,
                       input logic [W-1:0] ed, input logic [1:0] ecr);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.c = c;
        r.exp_v = ev; r.exp_yumi = ey; r.exp_data = ed; r.exp_cred = ecr;
        tbl.push_back(r);
    endtask

    logic [N-1:0][W-1:0] dt;
    logic [N-1:0][W-1:0] dr;
    logic [N-1:0]        vr;

    initial begin
        reset_i = 1'b1; v_i = '0; data_i = '0; credit_i = 1'b0;

        // Inputs 0 and 2 single-flit; later input 0 alone to exercise credits.
        dt = '0;
        dt[0] = 8'hA0;
        dt[2] = 8'hC0;
        add(1, 5'b00101, dt, 0, 0, 5'b00000, 8'h00, 2);
        add(0, 5'b00101, dt, 1, 1, 5'b00001, 8'hA0, 2);
        add(0, 5'b00101, dt, 1, 1, 5'b00100, 8'hC0, 2);
        add(0, 5'b00101, dt, 1, 1, 5'b00001, 8'hA0, 2);
        add(0, 5'b00101, dt, 1, 1, 5'b00100, 8'hC0, 2);
        add(0, 5'b00001, dt, 0, 1, 5'b00001, 8'hA0, 2);
        add(0, 5'b00001, dt, 0, 1, 5'b00001, 8'hA0, 1);
        add(0, 5'b00001, dt, 1, 0, 5'b00000, 8'h00, 0);
        add(0, 5'b00001, dt, 0, 1, 5'b00001, 8'hA0, 1);
        add(0, 5'b00001, dt, 0, 0, 5'b00000, 8'h00, 0);
        add(0, 5'b00000, dt, 1, 0, 5'b00000, 8'h00, 0);
        add(0, 5'b00001, dt, 1, 1, 5'b00001, 8'hA0, 1);
        add(0, 5'b00000, dt, 0, 0, 5'b00000, 8'h00, 1);

        drive(1, '0, '0, 0);
        tick();
        drive(1, '0, '0, 0);
        chk("reset_v_o", v_o, 1'b0);
        chk("reset_yumi_o", yumi_o, '0);
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d_v_o", i), v_o, tbl[i].exp_v);
            chk($sformatf("tbl%0d_yumi_o", i), yumi_o, tbl[i].exp_yumi);
            if (tbl[i].exp_v) chk($sformatf("tbl%0d_data_o", i), data_o, tbl[i].exp_data);
            chk($sformatf("tbl%0d_credits_o", i), credits_o, tbl[i].exp_cred);
            tick();
        end

        // Packet lock: header L=3 on input 1 holds the port for 4 flits despite input 3.
        drive(1, '0, '0, 0);
        tick();
        dt = '0;
        dt[1] = 8'h13;
        dt[3] = 8'h30;
        drive(0, 5'b01010, dt, 1);
        chk("lock_hdr_yumi", yumi_o, 5'b00010);
        chk("lock_hdr_data", data_o, 8'h13);
        tick();
        dt[1] = 8'h1F;
        for (int i = 0; i < 3; i++) begin
            drive(0, 5'b01010, dt, 1);
            chk($sformatf("lock_body%0d_yumi", i), yumi_o, 5'b00010);
            chk($sformatf("lock_body%0d_data", i), data_o, 8'h1F);
            tick();
        end
        drive(0, 5'b01010, dt, 1);
        chk("lock_release_yumi", yumi_o, 5'b01000);
        chk("lock_release_data", data_o, 8'h30);
        tick();

        // Reset mid-packet: ptr, lock, credits all cleared.
        drive(1, '0, '0, 0);
        tick();
        dt = '0;
        dt[3] = 8'h30;
        drive(0, 5'b01000, dt, 1);
        chk("rst_pre_single_yumi", yumi_o, 5'b01000);
        tick();
        dt[1] = 8'h13;
        drive(0, 5'b00010, dt, 1);
        chk("rst_pre_hdr_yumi", yumi_o, 5'b00010);
        tick();
        drive(0, 5'b00010, dt, 1);
        chk("rst_pre_body_yumi", yumi_o, 5'b00010);
        tick();
        drive(1, 5'b00010, dt, 0);
        chk("rst_mid_v_o", v_o, 1'b0);
        chk("rst_mid_yumi", yumi_o, 5'b00000);
        tick();
        dt = '0;
        dt[1] = 8'h10;
        dt[4] = 8'h40;
        drive(0, 5'b10010, dt, 1);
        chk("rst_post_credits", credits_o, 2'd2);
        chk("rst_post_yumi", yumi_o, 5'b00010);
        tick();
        drive(0, 5'b10010, dt, 1);
        chk("rst_post_unlocked_yumi", yumi_o, 5'b10000);
        tick();

        // Stall counting: drain credits, then hold a valid request for 7 cycles.
        drive(1, '0, '0, 0);
        tick();
        dt = '0;
        for (int i = 0; i < 2 + 7; i++) begin
            drive(0, 5'b00001, dt, 0);
            if (i == 2) chk("stall_starved_v_o", v_o, 1'b0);
            tick();
        end
        drive(0, 5'b00000, dt, 0);
        chk("stall_cnt_7", stall_cnt_o, stats_en ? 32'd7 : 32'd0);
        tick();

        // Randomized traffic against the model.
        drive(1, '0, '0, 0);
        tick();
        for (int n = 0; n < 3000; n++) begin
            vr = N'($urandom);
            for (int i = 0; i < N; i++) begin
                dr[i][W-1:LW] = (W - LW)'($urandom);
                dr[i][LW-1:0] = ($urandom_range(0, 2) == 0) ? LW'($urandom_range(1, 3)) : '0;
            end
            drive(($urandom_range(0, 99) == 0), vr, dr, 1'($urandom));
            // Never return a credit the downstream could not have consumed.
            if (!reset_i && credit_i && !e_v && m_cred == C) credit_i = 1'b0;
            model_check("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_mesh_router_out_sched.md
BSG_MESH_ROUTER_OUT_SCHED -- requirements
Module: bsg_mesh_router_out_sched

Interface
REQ-001 SHALL have parameter width_p, default -1 (must be overridden), flit width in bits.
REQ-002 SHALL have parameter num_in_p, default 5, number of requesting input FIFOs (SNEWP order).
REQ-003 SHALL have parameter credits_p, default 2, number of downstream FIFO slots.
REQ-004 SHALL have parameter len_width_p, default 4, width of the header length field in data_i[len_width_p-1:0].
REQ-005 SHALL have port clk_i, input, 1, the only clock.
REQ-006 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port v_i, input, num_in_p, request valid per input FIFO.
REQ-008 SHALL have port data_i, input, num_in_p x width_p, head flit per input FIFO.
REQ-009 SHALL have port yumi_o, input-FIFO dequeue, output, num_in_p, one-hot or zero.
REQ-010 SHALL have port v_o, output, 1, flit sent downstream this cycle.
REQ-011 SHALL have port data_o, output, width_p, flit sent.
REQ-012 SHALL have port credit_i, input, 1, one-cycle pulse returning one downstream slot.
REQ-013 SHALL have port credits_o, output, $clog2(credits_p+1), current credit count.
REQ-014 SHALL have port stall_cnt_o, output, 32, stall-cycle counter (see Configuration).

Function
REQ-015 States SHALL be IDLE and LOCKED.
REQ-016 A send SHALL occur when v_o=1; downstream always accepts, so no ready input exists.
REQ-017 v_o SHALL equal (granted input valid) AND (credit count > 0), combinationally, with zero-cycle latency from v_i.
REQ-018 yumi_o[g] SHALL equal v_o for the granted input g; all other bits 0; data_o = data_i[g].
REQ-019 In IDLE, grant SHALL go round-robin to the first valid input at or after ptr, wrapping from num_in_p-1 to 0.
REQ-020 IDLE send with header length L=0 SHALL stay IDLE and set ptr to g+1 (mod num_in_p).
REQ-021 IDLE send with L>0 SHALL enter LOCKED with lock=g and remaining=L.
REQ-022 In LOCKED, only input lock SHALL be eligible; other inputs' v_i ignored.
REQ-023 Each LOCKED send SHALL decrement remaining; the send at remaining=1 SHALL return to IDLE and set ptr to lock+1.
REQ-024 The credit counter SHALL decrement on send, increment on credit_i, and hold on both or neither.
REQ-025 credit_i while count=credits_p and no send SHALL saturate (no wrap) and fire a simulation error.
REQ-026 With count=0, v_o and yumi_o SHALL be 0 regardless of v_i; a same-cycle credit_i does not enable sending until the next cycle.

Reset
REQ-027 While reset_i=1, v_o=0, yumi_o=0, and state SHALL be IDLE.
REQ-028 On reset, ptr=0, remaining=0, credits=credits_p, stall_cnt_o=0, also when reset occurs mid-packet.

Configuration
REQ-029 With BSG_MESH_ROUTER_OUT_SCHED_STATS_EN defined, stall_cnt_o SHALL count cycles where a granted input is valid but count=0, saturating at 2^32-1.
REQ-030 Without BSG_MESH_ROUTER_OUT_SCHED_STATS_EN, stall_cnt_o SHALL be constant 0 and no counter logic is instantiated.

Structure
REQ-031 The IDLE/LOCKED state enum SHALL live in bsg_mesh_router_pkg.
REQ-032 The credit counter SHALL be the sub-module bsg_mesh_router_credit_counter (up/down, saturating, reset to credits_p).

Verification
REQ-033 Inputs 0,2 valid, single-flit (L=0), credits=2, credit_i returned every cycle -> grants 0,2,0,2; yumi_o alternates 5'b00001/5'b00100.
REQ-034 Input 1 header L=3, input 3 valid throughout -> 4 consecutive flits from input 1, then input 3 granted.
REQ-035 credits_p=2, no credit_i, input 0 streaming -> 2 sends, then v_o=0; one credit_i pulse -> exactly one more send the next cycle.
REQ-036 Send and credit_i in the same cycle at count=1 -> credits_o stays 1.
REQ-037 reset_i asserted in LOCKED with remaining=2 -> next cycle IDLE, ptr=0, credits_o=credits_p, v_o=0 during reset.
REQ-038 With STATS_EN, credits at 0 and input valid for 7 cycles -> stall_cnt_o=7; without it, stall_cnt_o=0.
